mem_subsys: RTL and testbench

Parametrised memory subsystem on the RISC CPU data side: one block holding address decode, a ROM array, a RAM array and a wait-state handshake engine. It replaces fixed combinational decode and zero-latency memories. Each region has a configurable base/mask and a wait-state count, and the block reports unmapped or illegal accesses with a bus-error response and a saturating error counter.

---
 rtl/mem_subsys_if.sv | 24 ++
 rtl/mem_subsys.sv | 129 ++++++++++++
 tb/tb_mem_subsys.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_subsys_if.sv
// Data-side memory bus between the CPU and mem_subsys: level request in,
// one-cycle ready/bus_err completion strobe out.
interface mem_subsys_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          bus_err;

    modport master (
        output addr, rd, wr, wdata,
        input  rdata, ready, bus_err
    );

    modport slave (
        input  addr, rd, wr, wdata,
        output rdata, ready, bus_err
    );
endinterface

// File: rtl/mem_subsys.sv
// Memory subsystem: base/mask address decode, ROM and RAM arrays and a
// wait-state engine that completes each access with a ready or bus-error strobe.
module mem_subsys #(
    parameter int            AW       = 13,
    parameter int            DW       = 8,
    parameter int            ROM_AW   = 9,
    parameter int            RAM_AW   = 10,
    parameter logic [AW-1:0] ROM_BASE = 13'h0000,
    parameter logic [AW-1:0] ROM_MASK = 13'h0800,
    parameter logic [AW-1:0] RAM_BASE = 13'h1800,
    parameter logic [AW-1:0] RAM_MASK = 13'h1800,
    parameter int            ROM_WS   = 1,
    parameter int            RAM_WS   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_subsys_if.slave bus,
    output logic        rom_en,
    output logic        ram_en,
    output logic [1:0]  state,
    output logic [7:0]  err_cnt
);

    localparam int IDX_W = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [DW-1:0] rom_mem [0:(1<<ROM_AW)-1];
    logic [DW-1:0] ram_mem [0:(1<<RAM_AW)-1];

    logic [IDX_W-1:0] addr_p0;
    logic [DW-1:0]    wdata_p0;
    logic             wr_p0;
    logic [3:0]       wcnt;
    logic [DW-1:0]    rdata_q;

    logic          req;
    logic          rom_hit;
    logic          ram_hit;
    logic          bad;
    logic [3:0]    ws_sel;
    logic [DW-1:0] rd_now;
    logic [DW-1:0] rd_held;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode of the live request; only acted on while idle.
    assign req     = bus.rd | bus.wr;
    assign rom_hit = (bus.addr & ROM_MASK) == ROM_BASE;
    assign ram_hit = (bus.addr & RAM_MASK) == RAM_BASE;
    assign bad     = (bus.rd & bus.wr) | (~rom_hit & ~ram_hit) | (bus.wr & rom_hit);
    assign ws_sel  = rom_hit ? 4'(ROM_WS) : 4'(RAM_WS);
    assign rd_now  = rom_hit ? rom_mem[bus.addr[ROM_AW-1:0]] : ram_mem[bus.addr[RAM_AW-1:0]];
    assign rd_held = rom_en  ? rom_mem[addr_p0[ROM_AW-1:0]]  : ram_mem[addr_p0[RAM_AW-1:0]];

    // Stage p0: request capture (data path, never reset)
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            addr_p0  <= bus.addr[IDX_W-1:0];
            wdata_p0 <= bus.wdata;
            wr_p0    <= bus.wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            rom_en  <= 1'b0;
            ram_en  <= 1'b0;
            err_cnt <= 8'd0;
            wcnt    <= 4'd0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (bad) begin
                            state   <= S_ERR;
                            rdata_q <= '0;
                            err_cnt <= sat_inc(err_cnt);
                        end else begin
                            rom_en <= rom_hit;
                            ram_en <= ~rom_hit;
                            wcnt   <= ws_sel;
                            if (ws_sel != 4'd0) begin
                                state <= S_WAIT;
                            end else begin
                                state <= S_ACK;
                                if (!bus.wr) rdata_q <= rd_now;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (wcnt <= 4'd1) begin
                        wcnt  <= 4'd0;
                        state <= S_ACK;
                        if (!wr_p0) rdata_q <= rd_held;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    rom_en <= 1'b0;
                    ram_en <= 1'b0;
                end
            endcase
        end
    end

    // Stage p1: write commit on the edge leaving ACK; a reset drops it because
    // the state is forced back to idle before the edge arrives.
    always_ff @(posedge clk) begin
        if (state == S_ACK && wr_p0) begin
            ram_mem[addr_p0[RAM_AW-1:0]] <= wdata_p0;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.ready   = (state == S_ACK) | (state == S_ERR);
    assign bus.bus_err = (state == S_ERR);

endmodule

// File: tb/tb_mem_subsys.sv
// Randomised self-checking bench for mem_subsys against a transaction-level
// model of the address map, latency and error counting.
module tb_mem_subsys;

    localparam int ROM_WS0 = 1;
    localparam int RAM_WS0 = 0;

    logic clk;
    logic rst_n0;
    logic rst_n3;

    logic       rom_en0, ram_en0, rom_en3, ram_en3;
    logic [1:0] state0, state3;
    logic [7:0] err_cnt0, err_cnt3;

    mem_subsys_if #(.AW(13), .DW(8)) bus0 ();
    mem_subsys_if #(.AW(13), .DW(8)) bus3 ();

    mem_subsys dut (
        .clk(clk), .rst_n(rst_n0), .bus(bus0),
        .rom_en(rom_en0), .ram_en(ram_en0), .state(state0), .err_cnt(err_cnt0)
    );

    mem_subsys #(.ROM_WS(2), .RAM_WS(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .bus(bus3),
        .rom_en(rom_en3), .ram_en(ram_en3), .state(state3), .err_cnt(err_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] rom_m [0:511];
    logic [7:0] ram_m [0:1023];
    int         err0;
    logic [7:0] last_rd0;

    // 0 = bus error, 1 = ROM, 2 = RAM. The 13-bit space splits into four
    // 2 KiB blocks: blocks 0 and 2 are ROM, block 3 is RAM, block 1 unmapped.
    function automatic int kind(input logic r, input logic wv, input logic [12:0] a);
        int blk;
        blk = int'(a) / 2048;
        if (r && wv) return 0;
        if (blk == 0 || blk == 2) return wv ? 0 : 1;
        if (blk == 3) return 2;
        return 0;
    endfunction

    task automatic predict(input logic r, input logic wv, input logic [12:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rdo, output logic be,
                           output logic re, output logic me, output logic [7:0] ec);
        int k;
        k   = kind(r, wv, a);
        be  = (k == 0);
        re  = (k == 1);
        me  = (k == 2);
        lat = (k == 1) ? ROM_WS0 + 1 : (k == 2) ? RAM_WS0 + 1 : 1;
        if (k == 0) begin
            last_rd0 = 8'h00;
            if (err0 < 255) err0++;
        end else if (r) begin
            last_rd0 = (k == 1) ? rom_m[int'(a) % 512] : ram_m[int'(a) % 1024];
        end else begin
            ram_m[int'(a) % 1024] = d;
        end
        rdo = last_rd0;
        ec  = err0[7:0];
    endtask

    task automatic drive(input int w, input logic r, input logic wv, input logic [12:0] a, input logic [7:0] d);
        if (w == 0) begin
            bus0.rd = r; bus0.wr = wv; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus3.rd = r; bus3.wr = wv; bus3.addr = a; bus3.wdata = d;
        end
    endtask

    // Issues one request, scrambles wdata after the sampling edge, and returns
    // what the DUT showed during its completion strobe (lat = -1 on timeout).
    task automatic access(input int w, input logic r, input logic wv, input logic [12:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] rdo, output logic be,
                          output logic re, output logic me, output logic [7:0] ec);
        lat = -1; rdo = 8'h00; be = 1'b0; re = 1'b0; me = 1'b0; ec = 8'h00;
        drive(w, r, wv, a, d);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                if (w == 0) bus0.wdata = ~d; else bus3.wdata = ~d;
            end
            if ((w == 0) ? bus0.ready : bus3.ready) begin
                lat = c;
                rdo = (w == 0) ? bus0.rdata   : bus3.rdata;
                be  = (w == 0) ? bus0.bus_err : bus3.bus_err;
                re  = (w == 0) ? rom_en0      : rom_en3;
                me  = (w == 0) ? ram_en0      : ram_en3;
                ec  = (w == 0) ? err_cnt0     : err_cnt3;
                break;
            end
        end
        drive(w, 1'b0, 1'b0, a, d);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({state0, bus0.ready, bus0.bus_err, bus0.rdata, rom_en0, ram_en0, err_cnt0} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d ready=%b err=%b rdata=%h rom_en=%b ram_en=%b err_cnt=%0d, required all zero",
                     state0, bus0.ready, bus0.bus_err, bus0.rdata, rom_en0, ram_en0, err_cnt0);
        end
    endtask

    task automatic test_rom_read;
        logic [1:0] s1, s2;
        logic       rdy1, rdy2, re2, be2, re3;
        logic [7:0] rd2;
        int elat; logic [7:0] erd, eec; logic ebe, ere, eme;
        rom_m[5] = 8'hA5;
        dut.rom_mem[5] = 8'hA5;
        predict(1'b1, 1'b0, 13'h0005, 8'h00, elat, erd, ebe, ere, eme, eec);
        drive(0, 1'b1, 1'b0, 13'h0005, 8'h00);
        @(posedge clk); #1; s1 = state0; rdy1 = bus0.ready;
        @(posedge clk); #1; s2 = state0; rdy2 = bus0.ready; rd2 = bus0.rdata; re2 = rom_en0; be2 = bus0.bus_err;
        drive(0, 1'b0, 1'b0, 13'h0005, 8'h00);
        @(posedge clk); #1;
        re3 = rom_en0;
        n_cmp++;
        if (s1 !== 2'd1 || rdy1 !== 1'b0 || s2 !== 2'd2 || rdy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL rom_read_seq: states %0d,%0d ready %b,%b, required states 1,2 ready 0,1", s1, s2, rdy1, rdy2);
        end
        n_cmp++;
        if (rd2 !== 8'hA5 || re2 !== 1'b1 || be2 !== 1'b0) begin
            n_fail++;
            $display("FAIL rom_read_data: rdata=%h rom_en=%b bus_err=%b, required A5 1 0", rd2, re2, be2);
        end
        n_cmp++;
        if (state0 !== 2'd0 || re3 !== 1'b0) begin
            n_fail++;
            $display("FAIL rom_read_idle: state=%0d rom_en=%b, required 0 0", state0, re3);
        end
    endtask

    task automatic test_ram_wr_rd;
        logic [12:0] addrs [3];
        logic        wvs [3];
        int lat, elat; logic [7:0] rdo, erd, ec, eec; logic be, re, me, ebe, ere, eme;
        addrs = '{13'h1802, 13'h1802, 13'h1C02};
        wvs   = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            predict(~wvs[i], wvs[i], addrs[i], 8'h3C, elat, erd, ebe, ere, eme, eec);
            access(0, ~wvs[i], wvs[i], addrs[i], 8'h3C, lat, rdo, be, re, me, ec);
            n_cmp++;
            if (lat !== 1 || be !== 1'b0 || me !== 1'b1 || (!wvs[i] && rdo !== 8'h3C) || rdo !== erd) begin
                n_fail++;
                $display("FAIL ram_wr_rd[%0d] addr=%h: lat=%0d bus_err=%b ram_en=%b rdata=%h, required lat=1 bus_err=0 ram_en=1 rdata=%h",
                         i, addrs[i], lat, be, me, rdo, erd);
            end
        end
        n_cmp++;
        if (dut.ram_mem[2] !== 8'h3C) begin
            n_fail++;
            $display("FAIL ram_array_word2: got %h, required 3C", dut.ram_mem[2]);
        end
    endtask

    task automatic test_errors;
        logic [12:0] addrs [3];
        logic        rs [3];
        logic        ws [3];
        logic [7:0]  cnts [3];
        int lat, elat; logic [7:0] rdo, erd, ec, eec; logic be, re, me, ebe, ere, eme;
        addrs = '{13'h0800, 13'h0010, 13'h1800};
        rs    = '{1'b1, 1'b0, 1'b1};
        ws    = '{1'b0, 1'b1, 1'b1};
        cnts  = '{8'd1, 8'd2, 8'd3};
        for (int i = 0; i < 3; i++) begin
            predict(rs[i], ws[i], addrs[i], 8'hEE, elat, erd, ebe, ere, eme, eec);
            access(0, rs[i], ws[i], addrs[i], 8'hEE, lat, rdo, be, re, me, ec);
            n_cmp++;
            if (lat !== 1 || be !== 1'b1 || rdo !== 8'h00 || re !== 1'b0 || me !== 1'b0 || ec !== cnts[i] || ec !== eec) begin
                n_fail++;
                $display("FAIL error[%0d] addr=%h: lat=%0d bus_err=%b rdata=%h rom_en=%b ram_en=%b err_cnt=%0d, required 1 1 00 0 0 %0d",
                         i, addrs[i], lat, be, rdo, re, me, ec, cnts[i]);
            end
        end
        n_cmp++;
        if (dut.rom_mem[16] !== rom_m[16]) begin
            n_fail++;
            $display("FAIL rom_write_blocked: rom[16]=%h, required %h", dut.rom_mem[16], rom_m[16]);
        end
    endtask

    task automatic test_random;
        logic [12:0] a; logic [7:0] d; logic r, wv; int x;
        int lat, elat; logic [7:0] rdo, erd, ec, eec; logic be, re, me, ebe, ere, eme;
        for (int n = 0; n < 150; n++) begin
            x  = $urandom_range(0, 19);
            r  = (x < 9) || (x >= 17);
            wv = (x >= 9);
            a  = ($urandom_range(0, 1) == 1) ? (13'h1800 | 13'($urandom_range(0, 2047))) : 13'($urandom_range(0, 8191));
            d  = 8'($urandom);
            predict(r, wv, a, d, elat, erd, ebe, ere, eme, eec);
            access(0, r, wv, a, d, lat, rdo, be, re, me, ec);
            n_cmp++;
            if (lat !== elat || rdo !== erd || be !== ebe || re !== ere || me !== eme || ec !== eec) begin
                n_fail++;
                $display("FAIL random[%0d] rd=%b wr=%b addr=%h: lat=%0d rdata=%h err=%b rom=%b ram=%b cnt=%0d, required %0d %h %b %b %b %0d",
                         n, r, wv, a, lat, rdo, be, re, me, ec, elat, erd, ebe, ere, eme, eec);
            end
        end
        for (int i = 0; i < 1024; i++) begin
            if (dut.ram_mem[i] !== ram_m[i]) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ram_contents[%0d]: got %h, required %h", i, dut.ram_mem[i], ram_m[i]);
            end
        end
        n_cmp++;
    endtask

    task automatic test_saturation;
        logic [12:0] a;
        int lat, elat; logic [7:0] rdo, erd, ec, eec; logic be, re, me, ebe, ere, eme;
        for (int n = 0; n < 260; n++) begin
            a = 13'h0800 + 13'($urandom_range(0, 2047));
            predict(1'b1, 1'b0, a, 8'h00, elat, erd, ebe, ere, eme, eec);
            access(0, 1'b1, 1'b0, a, 8'h00, lat, rdo, be, re, me, ec);
            n_cmp++;
            if (lat !== 1 || be !== 1'b1 || ec !== eec) begin
                n_fail++;
                $display("FAIL saturation[%0d]: lat=%0d bus_err=%b err_cnt=%0d, required 1 1 %0d", n, lat, be, ec, eec);
            end
        end
        n_cmp++;
        if (err_cnt0 !== 8'hFF) begin
            n_fail++;
            $display("FAIL saturation_final: err_cnt=%h, required FF", err_cnt0);
        end
    endtask

    task automatic test_back_to_back;
        int strobes; int pos [$]; logic [7:0] erd;
        int elat; logic [7:0] e_rd, eec; logic ebe, ere, eme;
        erd = ram_m[1];
        for (int i = 0; i < 3; i++) predict(1'b1, 1'b0, 13'h1801, 8'h00, elat, e_rd, ebe, ere, eme, eec);
        strobes = 0;
        drive(0, 1'b1, 1'b0, 13'h1801, 8'h00);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (bus0.ready) begin
                strobes++;
                pos.push_back(c);
                n_cmp++;
                if (bus0.rdata !== erd || bus0.bus_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL back_to_back_data cycle %0d: rdata=%h err=%b, required %h 0", c, bus0.rdata, bus0.bus_err, erd);
                end
            end
        end
        drive(0, 1'b0, 1'b0, 13'h1801, 8'h00);
        @(posedge clk); #1;
        n_cmp++;
        if (!(strobes == 3 && pos[0] == 1 && pos[1] == 3 && pos[2] == 5) || bus0.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_timing: %0d strobes, ready after release=%b, required 3 strobes at cycles 1,3,5 then 0",
                     strobes, bus0.ready);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat; logic [7:0] rdo, ec; logic be, re, me, rdy;
        dut3.ram_mem[16] = 8'h5A;
        access(3, 1'b1, 1'b0, 13'h0800, 8'h00, lat, rdo, be, re, me, ec);
        access(3, 1'b1, 1'b0, 13'h1810, 8'h00, lat, rdo, be, re, me, ec);
        n_cmp++;
        if (lat !== 4 || rdo !== 8'h5A || me !== 1'b1 || ec !== 8'd1) begin
            n_fail++;
            $display("FAIL ws3_read: lat=%0d rdata=%h ram_en=%b err_cnt=%0d, required 4 5A 1 1", lat, rdo, me, ec);
        end
        drive(3, 1'b0, 1'b1, 13'h1810, 8'h77);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (state3 !== 2'd1 || ram_en3 !== 1'b1) begin
            n_fail++;
            $display("FAIL ws3_in_wait: state=%0d ram_en=%b, required 1 1", state3, ram_en3);
        end
        rst_n3 = 1'b0;
        #1;
        n_cmp++;
        if ({state3, bus3.ready, bus3.bus_err, bus3.rdata, rom_en3, ram_en3, err_cnt3} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset_wait: state=%0d ready=%b err=%b rdata=%h rom_en=%b ram_en=%b err_cnt=%0d, required all zero",
                     state3, bus3.ready, bus3.bus_err, bus3.rdata, rom_en3, ram_en3, err_cnt3);
        end
        drive(3, 1'b0, 1'b0, 13'h1810, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n3 = 1'b1;
        n_cmp++;
        if (dut3.ram_mem[16] !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_in_wait_no_commit: ram[16]=%h, required 5A", dut3.ram_mem[16]);
        end
        drive(3, 1'b0, 1'b1, 13'h1810, 8'h77);
        rdy = 1'b0;
        for (int c = 0; c < 10 && !rdy; c++) begin
            @(posedge clk); #1;
            rdy = bus3.ready;
        end
        rst_n3 = 1'b0;
        drive(3, 1'b0, 1'b0, 13'h1810, 8'h00);
        @(posedge clk); #1;
        rst_n3 = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (rdy !== 1'b1 || dut3.ram_mem[16] !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_in_ack_no_commit: reached_ack=%b ram[16]=%h, required 1 5A", rdy, dut3.ram_mem[16]);
        end
        access(3, 1'b1, 1'b0, 13'h1810, 8'h00, lat, rdo, be, re, me, ec);
        n_cmp++;
        if (lat !== 4 || rdo !== 8'h5A || be !== 1'b0 || ec !== 8'd0) begin
            n_fail++;
            $display("FAIL read_after_reset: lat=%0d rdata=%h err=%b err_cnt=%0d, required 4 5A 0 0", lat, rdo, be, ec);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n0 = 1'b0;
        rst_n3 = 1'b0;
        drive(0, 1'b0, 1'b0, 13'h0000, 8'h00);
        drive(3, 1'b0, 1'b0, 13'h0000, 8'h00);
        err0 = 0;
        last_rd0 = 8'h00;
        for (int i = 0; i < 512; i++) begin
            rom_m[i] = 8'($urandom);
            dut.rom_mem[i] = rom_m[i];
        end
        for (int i = 0; i < 1024; i++) begin
            ram_m[i] = 8'($urandom);
            dut.ram_mem[i] = ram_m[i];
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n0 = 1'b1;
        rst_n3 = 1'b1;
        test_reset;
        test_rom_read;
        test_ram_wr_rd;
        test_errors;
        test_random;
        test_back_to_back;
        test_saturation;
        test_reset_mid_write;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
